// File: rtl/bsg_demux_one_hot_buffered.sv
// One-hot demux: a single staging register feeds a 2-entry FIFO per output channel.
// Define BSG_DEMUX_ONE_HOT_SEL_CHECK_EN to drop non-one-hot selects and flag them on error_o.
module bsg_demux_one_hot_buffered #(
  parameter int width_p = 28,
  parameter int els_p   = 2
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       v_i,
  input  logic [width_p-1:0]         data_i,
  input  logic [els_p-1:0]           sel_one_hot_i,
  output logic                       ready_o,
  output logic [els_p-1:0]           v_o,
  output logic [els_p*width_p-1:0]   data_o,
  input  logic [els_p-1:0]           yumi_i,
  output logic                       error_o
);

  localparam int lg_els_lp = $clog2(els_p);

  logic [lg_els_lp-1:0] sel_idx;
  logic                 sel_drop;
  logic                 transfer;

  logic                 stage_v;
  logic                 stage_drop;
  logic [lg_els_lp-1:0] stage_sel;
  logic [width_p-1:0]   stage_data;
  logic                 stage_move;

  logic [els_p-1:0]     full;

  // Scanning downward leaves the lowest set bit as the winner.
  always_comb begin
    sel_idx = '0;
    for (int i = els_p - 1; i >= 0; i--) begin
      if (sel_one_hot_i[i]) sel_idx = lg_els_lp'(i);
    end
  end

`ifdef BSG_DEMUX_ONE_HOT_SEL_CHECK_EN
  logic error_r;

  assign sel_drop = (sel_one_hot_i == '0)
                  | ((sel_one_hot_i & (sel_one_hot_i - els_p'(1))) != '0);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                   error_r <= 1'b0;
    else if (transfer & sel_drop)  error_r <= 1'b1;
  end

  assign error_o = error_r;
`else
  assign sel_drop = (sel_one_hot_i == '0);
  assign error_o  = 1'b0;
`endif

  // A dropped beat always leaves the stage; otherwise it waits for room in its FIFO.
  assign stage_move = stage_v & (stage_drop | ~full[stage_sel]);
  assign ready_o    = ~stage_v | stage_move;
  assign transfer   = v_i & ready_o;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)          stage_v <= 1'b0;
    else if (transfer)    stage_v <= 1'b1;
    else if (stage_move)  stage_v <= 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (transfer) begin
      stage_data <= data_i;
      stage_sel  <= sel_idx;
      stage_drop <= sel_drop;
    end
  end

  for (genvar i = 0; i < els_p; i++) begin : fifo
    logic [width_p-1:0] mem [2];
    logic               wptr;
    logic               rptr;
    logic               full_r;
    logic               empty_r;
    logic               enq;
    logic               deq;

    assign enq = stage_move & ~stage_drop & (stage_sel == lg_els_lp'(i));
    assign deq = yumi_i[i];

    // Enqueue only ever happens while not full, so flags follow from the prior state alone.
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        wptr    <= 1'b0;
        rptr    <= 1'b0;
        full_r  <= 1'b0;
        empty_r <= 1'b1;
      end else begin
        if (enq) wptr <= ~wptr;
        if (deq) rptr <= ~rptr;
        if (enq & ~deq) begin
          empty_r <= 1'b0;
          full_r  <= ~empty_r;
        end else if (deq & ~enq) begin
          full_r  <= 1'b0;
          empty_r <= ~full_r;
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (enq) mem[wptr] <= stage_data;
    end

    assign full[i]                        = full_r;
    assign v_o[i]                         = ~empty_r;
    assign data_o[i*width_p +: width_p]   = mem[rptr];
  end

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!reset_i) begin
      assert ((yumi_i & ~v_o) == '0)
        else $error("bsg_demux_one_hot_buffered: yumi_i=%b while v_o=%b", yumi_i, v_o);
    end
  end
`endif

endmodule
